// File: rtl/shiftcorrection_pipe_pkg.sv
// shiftcorr_pkg: shared configuration, helper functions and payload structs
// for the shiftcorrection_pipe block.
// Optional feature macro: SHIFTCORR_STICKY_EN (adds mf_sticky to the response).
// The payload structs are sized from the package configuration below. The top
// level refuses to elaborate with parameters that disagree with it.

package shiftcorr_pkg;

  // Default configuration (normalisation width, exponent field, max correction)
  localparam int SC_NORMSHIFTSZ = 16;
  localparam int SC_NE          = 8;
  localparam int SC_MAXCORR     = 2;

  // Nominal leading-one position of the normalisation shifter output
  function automatic int sc_nominal_pos(input int normshiftsz, input int maxcorr);
    return normshiftsz - 1 - maxcorr;
  endfunction

  // Width needed to carry a correction amount 0..maxcorr
  function automatic int sc_corr_width(input int maxcorr);
    return $clog2(maxcorr + 1);
  endfunction

  localparam int SC_P  = sc_nominal_pos(SC_NORMSHIFTSZ, SC_MAXCORR);
  localparam int SC_CW = sc_corr_width(SC_MAXCORR);
  localparam int SC_EW = SC_NE + 2;

  // Input payload captured by stage 1
  typedef struct packed {
    logic [SC_NORMSHIFTSZ-1:0] shifted;
    logic                      fma_op;
    logic                      div_op;
    logic                      div_res_subnorm;
    logic                      div_subnorm_shift_pos;
    logic [SC_EW-1:0]          div_ue;
    logic [SC_EW-1:0]          norm_sum_exp;
    logic                      fma_pre_result_subnorm;
    logic                      fma_s_zero;
  } shiftcorr_req_t;

  // Result payload held by stage 2
  typedef struct packed {
    logic [SC_NORMSHIFTSZ-1:0] mf;
    logic [SC_EW-1:0]          fma_me;
    logic [SC_EW-1:0]          ue;
    logic [SC_CW-1:0]          corr;
`ifdef SHIFTCORR_STICKY_EN
    logic                      mf_sticky;
`endif
  } shiftcorr_rsp_t;

endpackage

// File: rtl/shiftcorrection_pipe_if.sv
// shiftcorrection_pipe_if: input/output handshake and payload bundle.
// master = producer of inputs / consumer of results, slave = the pipe.
// Optional feature macro: SHIFTCORR_STICKY_EN (adds MfSticky).

interface shiftcorrection_pipe_if #(
  parameter int NORMSHIFTSZ = 16,
  parameter int NE          = 8,
  parameter int MAXCORR     = 2
);

  localparam int CW = $clog2(MAXCORR + 1);

  // upstream side
  logic                   InValid;
  logic                   InReady;
  logic [NORMSHIFTSZ-1:0] Shifted;
  logic                   FmaOp;
  logic                   DivOp;
  logic                   DivResSubnorm;
  logic                   DivSubnormShiftPos;
  logic [NE+1:0]          DivUe;
  logic [NE+1:0]          NormSumExp;
  logic                   FmaPreResultSubnorm;
  logic                   FmaSZero;

  // downstream side
  logic                   OutValid;
  logic                   OutReady;
  logic [NORMSHIFTSZ-1:0] Mf;
  logic [NE+1:0]          FmaMe;
  logic [NE+1:0]          Ue;
  logic [CW-1:0]          Corr;
`ifdef SHIFTCORR_STICKY_EN
  logic                   MfSticky;
`endif

  modport master (
    output InValid, output Shifted, output FmaOp, output DivOp,
    output DivResSubnorm, output DivSubnormShiftPos, output DivUe,
    output NormSumExp, output FmaPreResultSubnorm, output FmaSZero,
    output OutReady,
    input  InReady, input OutValid, input Mf, input FmaMe, input Ue,
`ifdef SHIFTCORR_STICKY_EN
    input  MfSticky,
`endif
    input  Corr
  );

  modport slave (
    input  InValid, input Shifted, input FmaOp, input DivOp,
    input  DivResSubnorm, input DivSubnormShiftPos, input DivUe,
    input  NormSumExp, input FmaPreResultSubnorm, input FmaSZero,
    input  OutReady,
    output InReady, output OutValid, output Mf, output FmaMe, output Ue,
`ifdef SHIFTCORR_STICKY_EN
    output MfSticky,
`endif
    output Corr
  );

endinterface

// File: rtl/shiftcorrection_pipe_corr_lod.sv
// corr_lod: leading-one detector over the top MAXCORR+1 bits of the
// normalisation shifter output. c_o is the index of the highest set bit
// within the field (which is the correction amount); z_o flags an empty field.

module corr_lod #(
  parameter int W  = 3,
  parameter int CW = 2
) (
  input  logic [W-1:0]  field_i,
  output logic [CW-1:0] c_o,
  output logic          z_o
);

  // Scan upward so the highest set bit is the last one written
  always_comb begin
    c_o = '0;
    for (int i = 0; i < W; i++) begin
      if (field_i[i]) begin
        c_o = CW'(i);
      end else begin
        c_o = c_o;
      end
    end
  end

  assign z_o = ~|field_i;

endmodule

// File: rtl/shiftcorrection_pipe.sv
// shiftcorrection_pipe: two-stage post-normalisation shift correction.
// Stage 1 captures the payload plus the leading-one correction c and the
// empty-field flag Z; stage 2 registers the top-aligned fraction and the
// corrected FMA / divsqrt exponents. valid/ready handshake with flush.
// Optional feature macro: SHIFTCORR_STICKY_EN (MfSticky output).

module shiftcorrection_pipe
  import shiftcorr_pkg::*;
#(
  parameter int NORMSHIFTSZ = SC_NORMSHIFTSZ,
  parameter int NE          = SC_NE,
  parameter int MAXCORR     = SC_MAXCORR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  shiftcorrection_pipe_if.slave bus
);

  localparam int P  = sc_nominal_pos(NORMSHIFTSZ, MAXCORR);
  localparam int CW = sc_corr_width(MAXCORR);
  localparam int EW = NE + 2;

  localparam logic [CW-1:0]          MC           = CW'(MAXCORR);
  localparam logic [CW:0]            MC_PLUS1     = (CW + 1)'(MAXCORR + 1);
  localparam logic [NORMSHIFTSZ-1:0] LOW_CLR_MASK =
    {{(NORMSHIFTSZ - MAXCORR - 1){1'b1}}, {(MAXCORR + 1){1'b0}}};
  localparam logic [EW-1:0]          EXP_ONE      = EW'(1);

  // The payload structs live in the package, so the parameters must agree
  if (NORMSHIFTSZ != SC_NORMSHIFTSZ || NE != SC_NE || MAXCORR != SC_MAXCORR) begin : g_cfg_check
    $error("shiftcorrection_pipe parameters differ from shiftcorr_pkg configuration");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s2_valid_q;
  logic s2_ready, s1_ready, in_fire, s1_move;

  assign s2_ready    = ~s2_valid_q | bus.OutReady;
  assign s1_ready    = ~s1_valid_q | s2_ready;
  assign bus.InReady = reset_n & s1_ready;
  assign in_fire     = bus.InValid & bus.InReady & ~flush;
  assign s1_move     = s1_valid_q & s2_ready & ~flush;

  // ---------------------------------------------------------------------------
  // Stage 1: leading-one detection and payload capture
  // ---------------------------------------------------------------------------
  shiftcorr_req_t s1_req_q, s1_req_d;
  logic [CW-1:0]  s1_c_q, lod_c;
  logic           s1_z_q, lod_z;

  corr_lod #(
    .W  (MAXCORR + 1),
    .CW (CW)
  ) u_lod (
    .field_i (bus.Shifted[NORMSHIFTSZ-1:P]),
    .c_o     (lod_c),
    .z_o     (lod_z)
  );

  // Pack the interface payload into the stage-1 request
  always_comb begin
    s1_req_d                        = '0;
    s1_req_d.shifted                = bus.Shifted;
    s1_req_d.fma_op                 = bus.FmaOp;
    s1_req_d.div_op                 = bus.DivOp;
    s1_req_d.div_res_subnorm        = bus.DivResSubnorm;
    s1_req_d.div_subnorm_shift_pos  = bus.DivSubnormShiftPos;
    s1_req_d.div_ue                 = bus.DivUe;
    s1_req_d.norm_sum_exp           = bus.NormSumExp;
    s1_req_d.fma_pre_result_subnorm = bus.FmaPreResultSubnorm;
    s1_req_d.fma_s_zero             = bus.FmaSZero;
  end

  // Stage valid bits: flush kills both stages, otherwise advance on ready
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= bus.InValid;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
      end
    end
  end

  // Stage-1 payload, correction amount and empty flag, loaded on acceptance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_req_q <= '0;
      s1_c_q   <= '0;
      s1_z_q   <= 1'b0;
    end else if (in_fire) begin
      s1_req_q <= s1_req_d;
      s1_c_q   <= lod_c;
      s1_z_q   <= lod_z;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fraction realignment and exponent correction
  // ---------------------------------------------------------------------------
  shiftcorr_rsp_t         s2_rsp_q, s2_rsp_d;
  logic                   div_clamp, corr_path, res_subnorm;
  logic [CW-1:0]          shift_amt;
  logic [CW:0]            lshift;
  logic [NORMSHIFTSZ-1:0] shifted_left;

  // Compute the corrected fraction and exponents from the stage-1 entry
  always_comb begin
    s2_rsp_d     = '0;
    res_subnorm  = s1_req_q.fma_pre_result_subnorm & s1_z_q;
    // divsqrt result at exponent 1 that under-corrects is pinned to the
    // maximum shift so the fraction lands in the subnormal position
    div_clamp    = s1_req_q.div_op & (s1_req_q.div_ue == EXP_ONE) & (s1_c_q < MC);
    corr_path    = s1_req_q.fma_op | (s1_req_q.div_op & ~s1_req_q.div_res_subnorm);

    if (s1_req_q.fma_op) begin
      shift_amt = s1_c_q;
    end else if (div_clamp) begin
      shift_amt = MC;
    end else begin
      shift_amt = s1_c_q;
    end

    // shift the leading one out the top so the fraction is top-aligned
    lshift       = MC_PLUS1 - {1'b0, shift_amt};
    shifted_left = s1_req_q.shifted << lshift;

    if (corr_path) begin
      s2_rsp_d.mf = shifted_left & LOW_CLR_MASK;
    end else begin
      s2_rsp_d.mf = s1_req_q.shifted;
    end

`ifdef SHIFTCORR_STICKY_EN
    if (corr_path) begin
      s2_rsp_d.mf_sticky = |(s1_req_q.shifted & ~({NORMSHIFTSZ{1'b1}} << shift_amt));
    end else begin
      s2_rsp_d.mf_sticky = 1'b0;
    end
`endif

    if (s1_req_q.fma_s_zero | res_subnorm) begin
      s2_rsp_d.fma_me = '0;
    end else begin
      s2_rsp_d.fma_me = s1_req_q.norm_sum_exp + EW'(s1_c_q)
                      + EW'(s1_req_q.fma_pre_result_subnorm);
    end

    if (s1_req_q.div_res_subnorm & s1_req_q.div_subnorm_shift_pos) begin
      s2_rsp_d.ue = '0;
    end else if ((s1_req_q.div_ue == EXP_ONE) & (s1_c_q < MC)) begin
      s2_rsp_d.ue = '0;
    end else begin
      s2_rsp_d.ue = s1_req_q.div_ue - EW'(MC - s1_c_q);
    end

    s2_rsp_d.corr = s1_c_q;
  end

  // Stage-2 result register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_rsp_q <= '0;
    end else if (s1_move) begin
      s2_rsp_q <= s2_rsp_d;
    end
  end

  assign bus.OutValid = s2_valid_q;
  assign bus.Mf       = s2_rsp_q.mf;
  assign bus.FmaMe    = s2_rsp_q.fma_me;
  assign bus.Ue       = s2_rsp_q.ue;
  assign bus.Corr     = s2_rsp_q.corr;
`ifdef SHIFTCORR_STICKY_EN
  assign bus.MfSticky = s2_rsp_q.mf_sticky;
`endif

endmodule

// File: tb/tb_shiftcorrection_pipe.sv
// Testbench for shiftcorrection_pipe: directed vectors with hand-derived
// expectations, back-pressure, flush and reset cases, then randomized traffic
// checked against an arithmetic reference model.

module tb_shiftcorrection_pipe;
  import shiftcorr_pkg::*;

  localparam int N    = 16;
  localparam int NE   = 8;
  localparam int MC   = 2;
  localparam int P    = N - 1 - MC;
  localparam int EMOD = 1 << (NE + 2);

  typedef struct {
    logic [N-1:0]  mf;
    logic [NE+1:0] me;
    logic [NE+1:0] ue;
    logic [1:0]    corr;
    logic          st;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  shiftcorrection_pipe_if #(.NORMSHIFTSZ(N), .NE(NE), .MAXCORR(MC)) bus ();

  shiftcorrection_pipe #(.NORMSHIFTSZ(N), .NE(NE), .MAXCORR(MC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  shiftcorr_req_t pend_q[$];
  exp_t           pend_exp_q[$];
  exp_t           exp_q[$];
  int             acc_q[$];

  int   ready_mode = 0;   // 0 always ready, 1 random, 2 never
  bit   valid_rand = 0;
  bit   strict_lat = 0;
  bit   flush_now = 0;
  bit   rst_now = 0;
  logic last_in_ready;
  bit   hold_v = 0;
  logic [N-1:0]  hold_mf;
  logic [NE+1:0] hold_me, hold_ue;
  logic [1:0]    hold_corr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic shiftcorr_req_t mk_req(logic [15:0] sh, bit fma, bit div, bit dsub,
                                            bit dpos, logic [9:0] ue, logic [9:0] nse,
                                            bit pre, bit sz);
    shiftcorr_req_t r;
    r.shifted = sh; r.fma_op = fma; r.div_op = div; r.div_res_subnorm = dsub;
    r.div_subnorm_shift_pos = dpos; r.div_ue = ue; r.norm_sum_exp = nse;
    r.fma_pre_result_subnorm = pre; r.fma_s_zero = sz;
    return r;
  endfunction

  function automatic exp_t mk_exp(logic [15:0] mf, logic [9:0] me, logic [9:0] ue,
                                  logic [1:0] corr, bit st);
    exp_t e;
    e.mf = mf; e.me = me; e.ue = ue; e.corr = corr; e.st = st;
    return e;
  endfunction

  // Reference model: plain arithmetic on integers
  function automatic exp_t model(shiftcorr_req_t r);
    exp_t e;
    int c = 0;
    bit z = 1;
    int sh, mf, s, me, ue;
    bit cp, clamp;
    for (int i = N - 1; i >= P; i--) begin
      if (z && r.shifted[i]) begin c = i - P; z = 0; end
    end
    clamp = (int'(r.div_ue) == 1) && (c < MC);
    cp    = r.fma_op || (r.div_op && !r.div_res_subnorm);
    sh    = r.fma_op ? c : (clamp ? MC : c);
    s     = int'(r.shifted);
    if (cp) begin
      mf = (s * (1 << (MC + 1 - sh))) % (1 << N);
      mf = mf - (mf % (1 << (MC + 1)));
    end else begin
      mf = s;
    end
    e.st = cp && ((s % (1 << sh)) != 0);
    if (r.fma_s_zero || (r.fma_pre_result_subnorm && z)) me = 0;
    else me = (int'(r.norm_sum_exp) + c + int'(r.fma_pre_result_subnorm)) % EMOD;
    if (r.div_res_subnorm && r.div_subnorm_shift_pos) ue = 0;
    else if ((int'(r.div_ue) == 1) && (c < MC)) ue = 0;
    else ue = (int'(r.div_ue) + EMOD - (MC - c)) % EMOD;
    e.mf = mf[N-1:0]; e.me = me[NE+1:0]; e.ue = ue[NE+1:0]; e.corr = c[1:0];
    return e;
  endfunction

  function automatic shiftcorr_req_t rnd_req();
    logic [31:0] t;
    int op;
    shiftcorr_req_t r;
    t = $urandom;
    r.shifted = t[15:0] >> $urandom_range(0, 3);
    op = $urandom_range(0, 3);
    r.fma_op = (op == 0) || (op == 3);
    r.div_op = (op == 1);
    t = $urandom;
    r.div_res_subnorm = t[0];
    r.div_subnorm_shift_pos = t[1];
    r.fma_pre_result_subnorm = t[2];
    r.fma_s_zero = (t[6:3] == 4'd0);
    r.div_ue = ($urandom_range(0, 3) == 0) ? 10'd1 : t[17:8];
    r.norm_sum_exp = t[27:18];
    return r;
  endfunction

  task automatic send(input shiftcorr_req_t r, input exp_t e);
    pend_q.push_back(r);
    pend_exp_q.push_back(e);
  endtask

  task automatic drive_req(input shiftcorr_req_t r);
    bus.Shifted = r.shifted; bus.FmaOp = r.fma_op; bus.DivOp = r.div_op;
    bus.DivResSubnorm = r.div_res_subnorm; bus.DivSubnormShiftPos = r.div_subnorm_shift_pos;
    bus.DivUe = r.div_ue; bus.NormSumExp = r.norm_sum_exp;
    bus.FmaPreResultSubnorm = r.fma_pre_result_subnorm; bus.FmaSZero = r.fma_s_zero;
  endtask

  // One clock: drive at negedge, evaluate handshakes just after, then posedge
  task automatic step();
    exp_t e;
    int a;
    shiftcorr_req_t r;
    @(negedge clk);
    flush   = flush_now;
    reset_n = ~rst_now;
    if (ready_mode == 0) bus.OutReady = 1'b1;
    else if (ready_mode == 1) bus.OutReady = ($urandom_range(0, 2) != 0);
    else bus.OutReady = 1'b0;
    if (rst_now) bus.OutReady = 1'b0;
    bus.InValid = (pend_q.size() > 0) && (!valid_rand || $urandom_range(0, 3) != 0);
    if (bus.InValid) drive_req(pend_q[0]);
    else drive_req(rnd_req());
    #1;
    last_in_ready = bus.InReady;
    if (hold_v) begin
      chk("hold_valid", 64'(bus.OutValid), 64'(1));
      chk("hold_data", {28'd0, bus.Mf, bus.FmaMe, bus.Ue, bus.Corr},
          {28'd0, hold_mf, hold_me, hold_ue, hold_corr});
    end
    hold_v = (bus.OutValid === 1'b1) && !bus.OutReady && !flush_now && !rst_now;
    hold_mf = bus.Mf; hold_me = bus.FmaMe; hold_ue = bus.Ue; hold_corr = bus.Corr;
    if (bus.OutValid === 1'b1 && bus.OutReady) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(bus.OutValid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("mf", 64'(bus.Mf), 64'(e.mf));
        chk("fma_me", 64'(bus.FmaMe), 64'(e.me));
        chk("ue", 64'(bus.Ue), 64'(e.ue));
        chk("corr", 64'(bus.Corr), 64'(e.corr));
`ifdef SHIFTCORR_STICKY_EN
        chk("mf_sticky", 64'(bus.MfSticky), 64'(e.st));
`endif
        if (strict_lat) chk("latency", 64'(cyc - a), 64'(2));
      end
    end
    if (flush_now || rst_now) begin
      exp_q.delete();
      acc_q.delete();
    end
    if (bus.InValid && bus.InReady === 1'b1) begin
      r = pend_q.pop_front();
      e = pend_exp_q.pop_front();
      if (!flush_now) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    if (pend_q.size() > 0 || exp_q.size() > 0)
      chk("drain_timeout", 64'(pend_q.size() + exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    #1;
    chk({tag, "_outvalid"}, 64'(bus.OutValid), 64'(0));
    chk({tag, "_outputs"}, {28'd0, bus.Mf, bus.FmaMe, bus.Ue, bus.Corr}, 64'(0));
  endtask

  shiftcorr_req_t rq;

  initial begin
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    drive_req(mk_req(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0));

    // reset state
    rst_now = 1;
    repeat (3) step();
    chk("rst_inready", 64'(last_in_ready), 64'(0));
    chk_reset_outputs("rst");
    rst_now = 0;

    // directed vectors, always-ready, exact two-cycle latency back to back
    strict_lat = 1;
    send(mk_req(16'h2000, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h0000, 10'd100, 10'd1022, 2'd0, 0));
    send(mk_req(16'hA010, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h4020, 10'd102, 10'd0,    2'd2, 0));
    send(mk_req(16'h4C00, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h3000, 10'd101, 10'd1023, 2'd1, 0));
    send(mk_req(16'h1000, 1, 0, 0, 0, 10'd0,  10'd100, 1, 0), mk_exp(16'h8000, 10'd0,   10'd1022, 2'd0, 0));
    send(mk_req(16'h5000, 0, 1, 0, 0, 10'd50, 10'd0,   0, 0), mk_exp(16'h4000, 10'd1,   10'd49,   2'd1, 0));
    send(mk_req(16'h2000, 0, 1, 0, 0, 10'd1,  10'd0,   0, 0), mk_exp(16'h4000, 10'd0,   10'd0,    2'd0, 0));
    send(mk_req(16'h5000, 0, 1, 1, 1, 10'd50, 10'd0,   0, 0), mk_exp(16'h5000, 10'd1,   10'd0,    2'd1, 0));
    send(mk_req(16'hA011, 0, 0, 0, 0, 10'd10, 10'd20,  0, 0), mk_exp(16'hA011, 10'd22,  10'd10,   2'd2, 0));
    send(mk_req(16'hA011, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h4020, 10'd102, 10'd0,    2'd2, 1));
    send(mk_req(16'h8000, 0, 1, 0, 0, 10'd1,  10'd0,   0, 0), mk_exp(16'h0000, 10'd2,   10'd1,    2'd2, 0));
    send(mk_req(16'h4000, 1, 0, 0, 0, 10'd0,  10'd5,   0, 1), mk_exp(16'h0000, 10'd0,   10'd1023, 2'd1, 0));
    send(mk_req(16'h8000, 1, 0, 0, 0, 10'd0,  10'd1023,0, 0), mk_exp(16'h0000, 10'd1,   10'd0,    2'd2, 0));
    send(mk_req(16'h0400, 0, 1, 0, 0, 10'd1,  10'd0,   0, 0), mk_exp(16'h0800, 10'd0,   10'd0,    2'd0, 0));
    send(mk_req(16'h3FFF, 0, 1, 1, 0, 10'd7,  10'd0,   0, 0), mk_exp(16'h3FFF, 10'd0,   10'd5,    2'd0, 0));
    send(mk_req(16'h6003, 1, 0, 0, 0, 10'd0,  10'd200, 0, 0), mk_exp(16'h8008, 10'd201, 10'd1023, 2'd1, 1));
    drain(100);
    strict_lat = 0;

    // back-pressure: three transactions, consumer stalled for four cycles
    ready_mode = 2;
    send(mk_req(16'hA010, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h4020, 10'd102, 10'd0,    2'd2, 0));
    send(mk_req(16'h4C00, 1, 0, 0, 0, 10'd0,  10'd100, 0, 0), mk_exp(16'h3000, 10'd101, 10'd1023, 2'd1, 0));
    send(mk_req(16'h5000, 0, 1, 0, 0, 10'd50, 10'd0,   0, 0), mk_exp(16'h4000, 10'd1,   10'd49,   2'd1, 0));
    step(); step(); step();
    chk("bp_inready_c3", 64'(last_in_ready), 64'(0));
    step();
    chk("bp_inready_c4", 64'(last_in_ready), 64'(0));
    chk("bp_pending", 64'(pend_q.size()), 64'(1));
    ready_mode = 0;
    drain(50);

    // flush with both stages full
    rq = rnd_req(); send(rq, model(rq));
    rq = rnd_req(); send(rq, model(rq));
    step(); step();
    ready_mode = 2; flush_now = 1;
    step();
    flush_now = 0; ready_mode = 0;
    #1 chk("flush_outvalid", 64'(bus.OutValid), 64'(0));
    // input presented together with flush is dropped
    rq = rnd_req(); send(rq, model(rq));
    flush_now = 1;
    step();
    flush_now = 0;
    repeat (4) step();
    chk("flush_discard", 64'(bus.OutValid), 64'(0));

    // reset with both stages full
    rq = rnd_req(); send(rq, model(rq));
    rq = rnd_req(); send(rq, model(rq));
    step(); step();
    rst_now = 1;
    step();
    rst_now = 0;
    chk("midrst_inready", 64'(last_in_ready), 64'(0));
    chk_reset_outputs("midrst");
    repeat (4) step();
    chk("midrst_no_stale", 64'(bus.OutValid), 64'(0));

    // randomized traffic with random handshakes and occasional flush
    valid_rand = 1;
    ready_mode = 1;
    for (int k = 0; k < 400; k++) begin
      rq = rnd_req();
      send(rq, model(rq));
    end
    for (int k = 0; k < 4000 && (pend_q.size() > 0 || exp_q.size() > 0); k++) begin
      flush_now = ($urandom_range(0, 59) == 0);
      step();
      flush_now = 0;
    end
    ready_mode = 0;
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
